max: RTL and testbench
======================

Name: max

Overview:
- Race-logic (temporal) MAX primitive: the output event occurs at the later of the two input arrival times within a gamma cycle.
- Events are pulse/level coded and sampled on the array clock aclk.
- It is a leaf cell inside temporal-coding datapaths (min/max/inhibit networks), one instance per pairwise max.

Parameters:
- GAMMA_CYCLE_WIDTH, 16: length of one gamma cycle in aclk cycles. Legal range is >= 2.
- PULSE_WIDTH, 8: number of aclk cycles y is held asserted per output event. Legal range is 1 .. GAMMA_CYCLE_WIDTH-1.

Ports:
- aclk  input  1  array clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset; sampled on the aclk rising edge.
- grst  input  1  synchronous active-high gamma-cycle restart strobe; forces a new gamma cycle.
- a  input  1  event input A (asserted level = arrived).
- b  input  1  event input B.
- y  output  1  registered MAX event output.

Behaviour:
- State: gamma counter gcnt[$clog2(GAMMA_CYCLE_WIDTH)-1:0], sticky flags a_seen/b_seen, fired flag, pulse counter pcnt[$clog2(PULSE_WIDTH+1)-1:0], registered y.
- Reset (rst_n=0 at an edge): gcnt=0, a_seen=b_seen=fired=0, pcnt=0, y=0 (idle level). Reset has priority over everything.
- Gamma boundary occurs when grst=1, or when gcnt==GAMMA_CYCLE_WIDTH-1 (auto-wrap). At the next edge:
  - gcnt=0;
  - a_seen, b_seen, fired, pcnt and y cleared;
  - inputs sampled that cycle are discarded.
- Otherwise gcnt increments by 1 each cycle.
- Arrival: a_seen <= a_seen | a; b_seen <= b_seen | b. Level-sampled, so an input already asserted at cycle start counts as arriving at the first sample. Input deassertion never clears a flag.
- Fire condition: both_now = (a_seen|a) & (b_seen|b) & ~fired. When true at edge k:
  - y=1, fired=1, pcnt=PULSE_WIDTH-1 from edge k;
  - latency is exactly 1 cycle after the later input is sampled asserted.
- While y=1 and pcnt>0: pcnt decrements each cycle. When pcnt==0, y returns to 0 at the next edge. y is high for exactly PULSE_WIDTH cycles unless truncated.
- Simultaneous arrival of a and b in the same sample fires on that sample, so y rises the next cycle.
- Only one input arrives (or neither): y stays 0 for the whole gamma cycle.
- At most one output pulse per gamma cycle (fired blocks re-trigger, even if inputs toggle off and on).
- Truncation: a pulse still active at a gamma boundary is cut; y=0 on the first cycle of the new gamma cycle.
- Reset mid-pulse: y=0 on the cycle after the reset edge.
- Combinational path from a/b to y: none.

Optional Feature:
- Macro MAX_FALLING_EN selects falling/active-low event encoding.
- Defined:
  - a and b are idle-high and arrive when low; flags use ~a/~b.
  - y idles 1 (reset value 1) and the output event is y=0 for PULSE_WIDTH cycles.
  - Timing is identical.
- Undefined: active-high encoding as above.

Decomposition:
- Package max_pkg:
  - localparam helpers for counter widths (GCNT_W, PCNT_W via $clog2);
  - an IDLE_LVL constant derived from MAX_FALLING_EN;
  - typedef logic [GCNT_W-1:0] gcnt_t.
- One natural sub-module, gamma_counter: gcnt, wrap and grst handling. It outputs a gamma_start strobe, which is reusable by sibling min/inhibit cells.
- Flags, fire logic and pulse stretch stay in max.

Test Plan:
- No inputs across a full 16-cycle gamma cycle -> y=0 throughout.
- a asserted at gamma cycle 2, b asserted at cycle 4, both later dropped -> y=1 cycles 5..12 (8 cycles), 0 otherwise.
- b at cycle 2, a at cycle 4 -> identical to previous: y=1 cycles 5..12.
- a and b asserted together at cycle 2 -> y=1 cycles 3..10. Toggling inputs again in the same cycle -> no second pulse.
- Late arrival: a at 0, b at 12 -> y=1 cycles 13..15, truncated; y=0 at cycle 0 of next gamma cycle. Also check that grst at cycle 7 clears a_seen so a later b alone gives y=0.
- rst_n=0 at cycle 6 of an active pulse -> y=0 from cycle 7 and all flags clear.
- Repeat the previous cases with MAX_FALLING_EN: idle-high inputs, with the polarity inverted on y.

Source files
------------

// File: rtl/max_pkg.sv
// Shared constants and types for the race-logic MAX cell and its siblings.
// MAX_FALLING_EN selects active-low event encoding on a, b and y.
package max_pkg;

    localparam int DEF_GAMMA_CYCLE_WIDTH = 16;
    localparam int DEF_PULSE_WIDTH       = 8;

    localparam int GCNT_W = $clog2(DEF_GAMMA_CYCLE_WIDTH);
    localparam int PCNT_W = $clog2(DEF_PULSE_WIDTH + 1);

`ifdef MAX_FALLING_EN
    localparam logic IDLE_LVL = 1'b1;
`else
    localparam logic IDLE_LVL = 1'b0;
`endif

    typedef logic [GCNT_W-1:0] gcnt_t;

    // Counter width that stays at least one bit for tiny ranges.
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/max_gamma_counter.sv
// Gamma-cycle timebase: free-running counter with auto-wrap and grst restart.
// gamma_start is high in the last cycle of a gamma cycle; the next edge begins a new one.
module gamma_counter
    import max_pkg::*;
#(
    parameter int GAMMA_CYCLE_WIDTH = DEF_GAMMA_CYCLE_WIDTH,
    localparam int GW = cnt_w(GAMMA_CYCLE_WIDTH)
) (
    input  logic aclk,
    input  logic rst_n,
    input  logic grst,
    output logic gamma_start
);

    logic [GW-1:0] gcnt_q;
    logic [GW-1:0] gcnt_d;

    always_comb begin
        gamma_start = grst | (gcnt_q == GW'(GAMMA_CYCLE_WIDTH - 1));
        gcnt_d      = gamma_start ? '0 : gcnt_q + GW'(1);
    end

    always_ff @(posedge aclk) begin
        if (!rst_n) begin
            gcnt_q <= '0;
        end else begin
            gcnt_q <= gcnt_d;
        end
    end

endmodule

// File: rtl/max.sv
// Race-logic MAX: emits one PULSE_WIDTH-cycle event one cycle after the later of a/b arrives.
// MAX_FALLING_EN inverts the event polarity of a, b and y (idle-high, active-low).
module max
    import max_pkg::*;
#(
    parameter int GAMMA_CYCLE_WIDTH = DEF_GAMMA_CYCLE_WIDTH,
    parameter int PULSE_WIDTH       = DEF_PULSE_WIDTH
) (
    input  logic aclk,
    input  logic rst_n,
    input  logic grst,
    input  logic a,
    input  logic b,
    output logic y
);

    localparam int PW = $clog2(PULSE_WIDTH + 1);

    logic          gamma_start;
    logic          a_act, b_act, a_arr, b_arr, y_active;
    logic          a_seen_q, a_seen_d;
    logic          b_seen_q, b_seen_d;
    logic          fired_q, fired_d;
    logic [PW-1:0] pcnt_q, pcnt_d;
    logic          y_q, y_d;

    gamma_counter #(
        .GAMMA_CYCLE_WIDTH(GAMMA_CYCLE_WIDTH)
    ) u_gamma_counter (
        .aclk        (aclk),
        .rst_n       (rst_n),
        .grst        (grst),
        .gamma_start (gamma_start)
    );

    assign a_act    = a ^ IDLE_LVL;
    assign b_act    = b ^ IDLE_LVL;
    assign a_arr    = a_seen_q | a_act;
    assign b_arr    = b_seen_q | b_act;
    assign y_active = (y_q != IDLE_LVL);

    always_comb begin
        a_seen_d = a_seen_q;
        b_seen_d = b_seen_q;
        fired_d  = fired_q;
        pcnt_d   = pcnt_q;
        y_d      = y_q;

        // A boundary discards everything sampled this cycle, including a pulse in flight.
        if (gamma_start) begin
            a_seen_d = 1'b0;
            b_seen_d = 1'b0;
            fired_d  = 1'b0;
            pcnt_d   = '0;
            y_d      = IDLE_LVL;
        end else begin
            a_seen_d = a_arr;
            b_seen_d = b_arr;
            if (a_arr && b_arr && !fired_q) begin
                fired_d = 1'b1;
                pcnt_d  = PW'(PULSE_WIDTH - 1);
                y_d     = ~IDLE_LVL;
            end else if (y_active) begin
                if (pcnt_q != '0) begin
                    pcnt_d = pcnt_q - PW'(1);
                end else begin
                    y_d = IDLE_LVL;
                end
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (!rst_n) begin
            a_seen_q <= 1'b0;
            b_seen_q <= 1'b0;
            fired_q  <= 1'b0;
            pcnt_q   <= '0;
            y_q      <= IDLE_LVL;
        end else begin
            a_seen_q <= a_seen_d;
            b_seen_q <= b_seen_d;
            fired_q  <= fired_d;
            pcnt_q   <= pcnt_d;
            y_q      <= y_d;
        end
    end

    assign y = y_q;

endmodule

// File: tb/tb_max.sv
// Scoreboard bench for the race-logic MAX cell with directed gamma-cycle vectors.
// Works in both the default build and with MAX_FALLING_EN defined.
module tb_max;

`ifdef MAX_FALLING_EN
    localparam logic IDLE = 1'b1;
`else
    localparam logic IDLE = 1'b0;
`endif

    typedef struct {
        logic y;
        int   test;
        int   cyc;
    } exp_t;

    logic aclk = 1'b0;
    logic rst_n, grst, a, b;
    logic y;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    bit   done     = 1'b0;

    max #(
        .GAMMA_CYCLE_WIDTH(16),
        .PULSE_WIDTH(8)
    ) dut (
        .aclk  (aclk),
        .rst_n (rst_n),
        .grst  (grst),
        .a     (a),
        .b     (b),
        .y     (y)
    );

    always #5 aclk = ~aclk;

    function automatic logic [31:0] rng(input int lo, input int hi);
        logic [31:0] m;
        m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    // Drives one vector: bit c of each mask is the value during cycle c (rst_v = reset asserted).
    // Called right after a rising edge; expected y for every cycle goes to the scoreboard.
    task automatic applyStimulus(input int test, input int ncyc,
                                 input logic [31:0] a_v, input logic [31:0] b_v,
                                 input logic [31:0] g_v, input logic [31:0] rst_v,
                                 input logic [31:0] y_v);
        exp_t e;
        for (int c = 0; c < ncyc; c++) begin
            a     = a_v[c] ^ IDLE;
            b     = b_v[c] ^ IDLE;
            grst  = g_v[c];
            rst_n = ~rst_v[c];
            e.y    = y_v[c] ^ IDLE;
            e.test = test;
            e.cyc  = c;
            exp_q.push_back(e);
            @(posedge aclk);
            #1;
        end
    endtask

    task automatic checkOutput(input exp_t e, input logic got);
        checks++;
        if (got !== e.y) begin
            failures++;
            $display("[TB] FAIL y T%0d cyc %0d: got %b expected %b", e.test, e.cyc, got, e.y);
        end
    endtask

    always @(negedge aclk) begin
        if (!done && exp_q.size() > 0) begin
            checkOutput(exp_q.pop_front(), y);
        end
    end

    initial begin
        exp_t e;
        rst_n = 1'b0;
        grst  = 1'b0;
        a     = IDLE;
        b     = IDLE;
        @(posedge aclk);
        #1;
        e.y = IDLE; e.test = 99; e.cyc = 0;
        exp_q.push_back(e);
        @(posedge aclk);
        #1;
        rst_n = 1'b1;

        $display("[TB] T0 idle gamma cycle");
        applyStimulus(0, 16, '0, '0, '0, '0, '0);
        $display("[TB] T1 a@2 b@4");
        applyStimulus(1, 16, rng(2, 6), rng(4, 6), '0, '0, rng(5, 12));
        $display("[TB] T2 b@2 a@4");
        applyStimulus(2, 16, rng(4, 6), rng(2, 6), '0, '0, rng(5, 12));
        $display("[TB] T3 simultaneous, re-toggle");
        applyStimulus(3, 16, rng(2, 3) | rng(12, 13), rng(2, 3) | rng(12, 13),
                      '0, '0, rng(3, 10));
        $display("[TB] T4 late arrival truncated");
        applyStimulus(4, 32, rng(0, 0), rng(12, 12), '0, '0, rng(13, 15));
        $display("[TB] T5 grst clears a_seen");
        applyStimulus(5, 24, rng(2, 2), rng(10, 10), rng(7, 7), '0, '0);
        $display("[TB] T6 reset mid-pulse");
        applyStimulus(6, 23, rng(2, 2), rng(2, 2) | rng(8, 8), '0, rng(6, 6), rng(3, 6));
        $display("[TB] T7 recovery after reset");
        applyStimulus(7, 16, rng(5, 5), rng(5, 5), '0, '0, rng(6, 13));

        @(negedge aclk);
        #1;
        done = 1'b1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
